// File: rtl/fp_result_byte_tx.sv
// fp_result_byte_tx: serialises one DATA_W-bit ALU result plus its four status flags
// into a byte frame for the pin-limited output port.
// Frame: header {HDR_TAG, flags}, then the result bytes MSB first.
// The reader paces the frame with tx_ack.
// Build option: define TX_CHECKSUM_EN to append an XOR checksum byte to every frame.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for a result; res_ready high
// S_HDR  | header byte presented
// S_DATA | result byte idx presented (MSB first)
// S_CSUM | checksum byte presented (TX_CHECKSUM_EN builds only)

module fp_result_byte_tx #(
  parameter int         DATA_W  = 32,
  parameter logic [3:0] HDR_TAG = 4'hA
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res_data,
  input  logic [3:0]        res_flags,
  output logic              res_ready,
  output logic [7:0]        tx_byte,
  output logic              tx_valid,
  input  logic              tx_ack,
  output logic              tx_last,
  output logic              tx_busy
);

  localparam int NBYTES = DATA_W / 8;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_DATA
`ifdef TX_CHECKSUM_EN
    , S_CSUM
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic              tx_valid_q, tx_valid_d;
  logic              tx_last_q, tx_last_d;
  logic              tx_busy_q, tx_busy_d;
  logic              res_ready_q, res_ready_d;
`ifdef TX_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic              xfer;
  logic [DATA_W-1:0] shreg_shift;
  logic [IDX_W-1:0]  idx_inc;

  // Next-state and registered-output logic; everything holds while ena is low.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    idx_d       = idx_q;
    tx_byte_d   = tx_byte_q;
    tx_valid_d  = tx_valid_q;
    tx_last_d   = tx_last_q;
    tx_busy_d   = tx_busy_q;
    res_ready_d = res_ready_q;
`ifdef TX_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    xfer        = tx_valid_q && tx_ack;
    shreg_shift = shreg_q << 8;
    idx_inc     = idx_q + 1'b1;

    if (ena) begin
      case (state_q)
        S_IDLE: begin
          if (res_valid && res_ready_q) begin
            shreg_d     = res_data;
            tx_byte_d   = {HDR_TAG, res_flags};
            tx_valid_d  = 1'b1;
            tx_last_d   = 1'b0;
            tx_busy_d   = 1'b1;
            res_ready_d = 1'b0;
            state_d     = S_HDR;
`ifdef TX_CHECKSUM_EN
            csum_d      = {HDR_TAG, res_flags};
`endif
          end
        end

        S_HDR: begin
          if (xfer) begin
            tx_byte_d = shreg_q[DATA_W-1 -: 8];
            idx_d     = '0;
            state_d   = S_DATA;
`ifdef TX_CHECKSUM_EN
            csum_d    = csum_q ^ shreg_q[DATA_W-1 -: 8];
`else
            tx_last_d = (NBYTES == 1);
`endif
          end
        end

        S_DATA: begin
          if (xfer) begin
            if (idx_q == IDX_LAST) begin
`ifdef TX_CHECKSUM_EN
              // csum_q already folds in every byte presented so far.
              tx_byte_d   = csum_q;
              tx_last_d   = 1'b1;
              state_d     = S_CSUM;
`else
              tx_valid_d  = 1'b0;
              tx_last_d   = 1'b0;
              tx_busy_d   = 1'b0;
              res_ready_d = 1'b1;
              state_d     = S_IDLE;
`endif
            end else begin
              shreg_d   = shreg_shift;
              tx_byte_d = shreg_shift[DATA_W-1 -: 8];
              idx_d     = idx_inc;
`ifdef TX_CHECKSUM_EN
              csum_d    = csum_q ^ shreg_shift[DATA_W-1 -: 8];
`else
              tx_last_d = (idx_inc == IDX_LAST);
`endif
            end
          end
        end

`ifdef TX_CHECKSUM_EN
        S_CSUM: begin
          if (xfer) begin
            tx_valid_d  = 1'b0;
            tx_last_d   = 1'b0;
            tx_busy_d   = 1'b0;
            res_ready_d = 1'b1;
            state_d     = S_IDLE;
          end
        end
`endif

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      shreg_q     <= '0;
      idx_q       <= '0;
      tx_byte_q   <= 8'h00;
      tx_valid_q  <= 1'b0;
      tx_last_q   <= 1'b0;
      tx_busy_q   <= 1'b0;
      res_ready_q <= 1'b1;
`ifdef TX_CHECKSUM_EN
      csum_q      <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      idx_q       <= idx_d;
      tx_byte_q   <= tx_byte_d;
      tx_valid_q  <= tx_valid_d;
      tx_last_q   <= tx_last_d;
      tx_busy_q   <= tx_busy_d;
      res_ready_q <= res_ready_d;
`ifdef TX_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign res_ready = res_ready_q;
  assign tx_byte   = tx_byte_q;
  assign tx_valid  = tx_valid_q;
  assign tx_last   = tx_last_q;
  assign tx_busy   = tx_busy_q;

endmodule

// File: tb/tb_fp_result_byte_tx.sv
// Bench for fp_result_byte_tx: a reference model pushes each expected frame byte
// ({last, byte}) into a queue when a result is offered; bytes are popped and compared
// as the DUT presents them. Inputs are driven and outputs sampled on the falling edge.
// Works for both the default build and TX_CHECKSUM_EN builds.

module tb_fp_result_byte_tx;

  localparam int DATA_W = 32;
  localparam int NB     = DATA_W / 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b0;
  logic        res_valid = 1'b0;
  logic [31:0] res_data = '0;
  logic [3:0]  res_flags = '0;
  logic        tx_ack = 1'b0;
  logic        res_ready;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_last;
  logic        tx_busy;

  int n_pass  = 0;
  int n_total = 0;

  logic [8:0] exp_q[$];

  fp_result_byte_tx #(
    .DATA_W (DATA_W),
    .HDR_TAG(4'hA)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .res_valid(res_valid),
    .res_data (res_data),
    .res_flags(res_flags),
    .res_ready(res_ready),
    .tx_byte  (tx_byte),
    .tx_valid (tx_valid),
    .tx_ack   (tx_ack),
    .tx_last  (tx_last),
    .tx_busy  (tx_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  // Reference model of one frame: header, MSB-first data, optional XOR checksum.
  task automatic push_frame(input logic [31:0] d, input logic [3:0] f);
    logic [7:0] b;
    logic [7:0] cs;
    b  = {4'hA, f};
    cs = b;
    exp_q.push_back({1'b0, b});
    for (int i = 0; i < NB; i++) begin
      b  = d[31 - 8*i -: 8];
      cs = cs ^ b;
`ifdef TX_CHECKSUM_EN
      exp_q.push_back({1'b0, b});
`else
      exp_q.push_back({(i == NB - 1), b});
`endif
    end
`ifdef TX_CHECKSUM_EN
    exp_q.push_back({1'b1, cs});
`endif
  endtask

  task automatic start_frame(input logic [31:0] d, input logic [3:0] f);
    res_valid = 1'b1;
    res_data  = d;
    res_flags = f;
    push_frame(d, f);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; tx_ack = 1'b0; res_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if ({res_ready, tx_valid, tx_last, tx_busy, tx_byte} !== {4'b1000, 8'h00}) begin
      $display("FAIL reset_vals: got rdy=%b v=%b last=%b busy=%b byte=%h, want rdy=1 v=0 last=0 busy=0 byte=00",
               res_ready, tx_valid, tx_last, tx_busy, tx_byte);
    end else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_total++;
    if ({res_ready, tx_valid, tx_busy} !== 3'b100) begin
      $display("FAIL reset_idle: got rdy=%b v=%b busy=%b, want 1 0 0", res_ready, tx_valid, tx_busy);
    end else n_pass++;
  endtask

  task automatic test_basic();
    logic [8:0] exp;
    int k;
    tx_ack = 1'b1;
    n_total++;
    if (res_ready !== 1'b1) $display("FAIL basic_ready_pre: got %b want 1", res_ready);
    else n_pass++;
    start_frame(32'h3F800000, 4'b0001);
    @(negedge clk);
    res_valid = 1'b0;
    k = 0;
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      n_total++;
      if ({tx_valid, tx_busy, res_ready, tx_last, tx_byte} !== {3'b110, exp})
        $display("FAIL basic_byte%0d: got v=%b busy=%b rdy=%b last=%b byte=%h, want v=1 busy=1 rdy=0 last=%b byte=%h",
                 k, tx_valid, tx_busy, res_ready, tx_last, tx_byte, exp[8], exp[7:0]);
      else n_pass++;
      k++;
      @(negedge clk);
    end
    n_total++;
    if ({tx_valid, tx_busy, res_ready, tx_last} !== 4'b0010)
      $display("FAIL basic_end: got v=%b busy=%b rdy=%b last=%b, want 0 0 1 0", tx_valid, tx_busy, res_ready, tx_last);
    else n_pass++;
  endtask

  task automatic test_stall();
    logic [8:0] exp;
    int k;
    tx_ack = 1'b1;
    start_frame(32'h3F800000, 4'b0001);
    @(negedge clk);
    res_valid = 1'b0;
    k = 0;
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      n_total++;
      if ({tx_valid, tx_busy, tx_last, tx_byte} !== {2'b11, exp})
        $display("FAIL stall_byte%0d: got v=%b busy=%b last=%b byte=%h, want v=1 busy=1 last=%b byte=%h",
                 k, tx_valid, tx_busy, tx_last, tx_byte, exp[8], exp[7:0]);
      else n_pass++;
      if (k == 1) begin
        tx_ack = 1'b0;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          n_total++;
          if ({tx_valid, tx_last, tx_byte} !== {1'b1, 1'b0, 8'h3F})
            $display("FAIL stall_hold%0d: got v=%b last=%b byte=%h, want v=1 last=0 byte=3f",
                     s, tx_valid, tx_last, tx_byte);
          else n_pass++;
        end
        tx_ack = 1'b1;
      end
      k++;
      @(negedge clk);
    end
    n_total++;
    if ({tx_valid, res_ready} !== 2'b01)
      $display("FAIL stall_end: got v=%b rdy=%b, want 0 1", tx_valid, res_ready);
    else n_pass++;
  endtask

  task automatic test_busy();
    logic [8:0] exp;
    int k;
    tx_ack = 1'b1;
    start_frame(32'h12345678, 4'h5);
    @(negedge clk);
    res_valid = 1'b0;
    k = 0;
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      n_total++;
      if ({tx_valid, res_ready, tx_last, tx_byte} !== {2'b10, exp})
        $display("FAIL busy_byte%0d: got v=%b rdy=%b last=%b byte=%h, want v=1 rdy=0 last=%b byte=%h",
                 k, tx_valid, res_ready, tx_last, tx_byte, exp[8], exp[7:0]);
      else n_pass++;
      if (k == 2) begin
        res_valid = 1'b1; res_data = 32'hDEADBEEF; res_flags = 4'hC;
      end
      if (k == 3) res_flags = 4'h6;
      k++;
      @(negedge clk);
    end
    n_total++;
    if ({tx_valid, res_ready} !== 2'b01)
      $display("FAIL busy_gap: got v=%b rdy=%b, want 0 1", tx_valid, res_ready);
    else n_pass++;
    push_frame(32'hDEADBEEF, 4'h6);
    @(negedge clk);
    res_valid = 1'b0;
    k = 0;
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      n_total++;
      if ({tx_valid, tx_last, tx_byte} !== {1'b1, exp})
        $display("FAIL busy_next%0d: got v=%b last=%b byte=%h, want v=1 last=%b byte=%h",
                 k, tx_valid, tx_last, tx_byte, exp[8], exp[7:0]);
      else n_pass++;
      k++;
      @(negedge clk);
    end
    n_total++;
    if ({tx_valid, res_ready} !== 2'b01)
      $display("FAIL busy_end: got v=%b rdy=%b, want 0 1", tx_valid, res_ready);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [8:0] exp;
    int k;
    tx_ack = 1'b1;
    start_frame(32'hCAFEF00D, 4'h2);
    @(negedge clk);
    res_valid = 1'b0;
    for (k = 0; k < 2; k++) begin
      exp = exp_q.pop_front();
      n_total++;
      if ({tx_valid, tx_byte} !== {1'b1, exp[7:0]})
        $display("FAIL rstmid_byte%0d: got v=%b byte=%h, want v=1 byte=%h", k, tx_valid, tx_byte, exp[7:0]);
      else n_pass++;
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    n_total++;
    if ({tx_valid, tx_busy, res_ready, tx_last, tx_byte} !== {4'b0010, 8'h00})
      $display("FAIL rstmid_vals: got v=%b busy=%b rdy=%b last=%b byte=%h, want 0 0 1 0 00",
               tx_valid, tx_busy, res_ready, tx_last, tx_byte);
    else n_pass++;
    start_frame(32'h0BADC0DE, 4'h8);
    @(negedge clk);
    res_valid = 1'b0;
    k = 0;
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      n_total++;
      if ({tx_valid, tx_last, tx_byte} !== {1'b1, exp})
        $display("FAIL rstmid_new%0d: got v=%b last=%b byte=%h, want v=1 last=%b byte=%h",
                 k, tx_valid, tx_last, tx_byte, exp[8], exp[7:0]);
      else n_pass++;
      k++;
      @(negedge clk);
    end
  endtask

  task automatic test_ena_freeze();
    logic [8:0] exp;
    int k;
    tx_ack = 1'b1;
    start_frame(32'h40490FDB, 4'h4);
    @(negedge clk);
    res_valid = 1'b0;
    ena = 1'b0;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      n_total++;
      if ({tx_valid, tx_busy, res_ready, tx_last, tx_byte} !== {4'b1100, exp_q[0][7:0]})
        $display("FAIL freeze_hold%0d: got v=%b busy=%b rdy=%b last=%b byte=%h, want 1 1 0 0 %h",
                 s, tx_valid, tx_busy, res_ready, tx_last, tx_byte, exp_q[0][7:0]);
      else n_pass++;
    end
    ena = 1'b1;
    k = 0;
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      n_total++;
      if ({tx_valid, tx_last, tx_byte} !== {1'b1, exp})
        $display("FAIL freeze_byte%0d: got v=%b last=%b byte=%h, want v=1 last=%b byte=%h",
                 k, tx_valid, tx_last, tx_byte, exp[8], exp[7:0]);
      else n_pass++;
      k++;
      @(negedge clk);
    end
    n_total++;
    if ({tx_valid, res_ready} !== 2'b01)
      $display("FAIL freeze_end: got v=%b rdy=%b, want 0 1", tx_valid, res_ready);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [8:0] exp;
    int k;
    tx_ack = 1'b1;
    for (int f = 0; f < 3; f++) begin
      n_total++;
      if (res_ready !== 1'b1) $display("FAIL b2b_ready%0d: got %b want 1", f, res_ready);
      else n_pass++;
      start_frame($urandom, 4'($urandom_range(15, 0)));
      @(negedge clk);
      res_valid = 1'b0;
      k = 0;
      while (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        n_total++;
        if ({tx_valid, tx_last, tx_byte} !== {1'b1, exp})
          $display("FAIL b2b_f%0d_byte%0d: got v=%b last=%b byte=%h, want v=1 last=%b byte=%h",
                   f, k, tx_valid, tx_last, tx_byte, exp[8], exp[7:0]);
        else n_pass++;
        k++;
        @(negedge clk);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_busy();
    test_reset_mid();
    test_ena_freeze();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
